// File: rtl/regfile_debug_port.sv
// Debug access to the core register file: halts the core, then streams x0/x1..x31
// out (DUMP) or refills x1..x31 from an input stream (LOAD).
module regfile_debug_port #(
    parameter bit DUMP_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    input  logic        cmd_op,
    output logic        cmd_ready,
    output logic [4:0]  rf_read_reg,
    input  logic [31:0] rf_read_data,
    output logic        rf_we,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout_data,
    output logic        dout_last,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din_data,
    output logic        core_halt
);

    localparam int          DATA_W   = 32;
    localparam logic [4:0]  LAST_IDX = 5'd31;
    localparam logic        OP_DUMP  = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DUMP = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_core_halt;
    logic [4:0]          r_idx;
    logic                r_issued_all;
    logic [DATA_W-1:0]   r_dout_data_p0;
    logic                r_vld_p0;
    logic                r_last_p0;

    logic                w_cmd_ready;
    logic                w_din_ready;
    logic                w_accept;
    logic                w_capture;
    logic                w_dout_fire;
    logic                w_load_fire;

    function automatic logic [4:0] start_idx(input logic op);
        start_idx = (op == OP_DUMP && DUMP_ZERO) ? 5'd0 : 5'd1;
    endfunction

    // State register; core_halt is registered alongside the state it mirrors.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_core_halt <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_core_halt <= (w_next_state != S_IDLE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next_state = (cmd_op == OP_DUMP) ? S_DUMP : S_LOAD;
            end
            S_DUMP: begin
                if (w_dout_fire && r_last_p0)
                    w_next_state = S_IDLE;
            end
            S_LOAD: begin
                if (w_load_fire && r_idx == LAST_IDX)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake and register-file port decode; everything is held off while RST is high.
    always_comb begin
        w_cmd_ready   = (r_state == S_IDLE) && !RST;
        w_din_ready   = (r_state == S_LOAD) && !RST;
        w_accept      = cmd_valid && w_cmd_ready;
        w_load_fire   = din_valid && w_din_ready;
        w_dout_fire   = r_vld_p0 && dout_ready;
        w_capture     = (r_state == S_DUMP) && !r_issued_all && (!r_vld_p0 || dout_ready);

        cmd_ready     = w_cmd_ready;
        din_ready     = w_din_ready;
        rf_we         = w_load_fire;
        rf_write_reg  = r_idx;
        rf_write_data = din_data;
        rf_read_reg   = ((r_state == S_DUMP) && !RST) ? r_idx : 5'd0;
        core_halt     = r_core_halt;
    end

    // Stage p0: the word read at r_idx is captured into the output holding register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx          <= 5'd0;
            r_issued_all   <= 1'b0;
            r_vld_p0       <= 1'b0;
            r_last_p0      <= 1'b0;
            r_dout_data_p0 <= '0;
        end else begin
            if (w_accept) begin
                r_idx        <= start_idx(cmd_op);
                r_issued_all <= 1'b0;
            end else if (w_capture || w_load_fire) begin
                r_idx <= r_idx + 5'd1;
            end

            // r_issued_all stops the wrap of r_idx back to 0 from producing a 33rd word.
            if (w_capture) begin
                r_dout_data_p0 <= rf_read_data;
                r_vld_p0       <= 1'b1;
                r_last_p0      <= (r_idx == LAST_IDX);
                if (r_idx == LAST_IDX)
                    r_issued_all <= 1'b1;
            end else if (w_dout_fire) begin
                r_vld_p0  <= 1'b0;
                r_last_p0 <= 1'b0;
            end
        end
    end

    assign dout_valid = r_vld_p0;
    assign dout_data  = r_dout_data_p0;
    assign dout_last  = r_last_p0;

endmodule

// File: doc/regfile_debug_port.md
REGFILE_DEBUG_PORT -- requirements
Module: regfile_debug_port

Interface
REQ-001 SHALL have parameter: DUMP_ZERO, 1, dump starts at x0 (32 words) when 1, at x1 (31 words) when 0.
REQ-002 SHALL have port: CLK  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: cmd_valid  in  1  command request.
REQ-005 SHALL have port: cmd_op  in  1  0 = DUMP, 1 = LOAD.
REQ-006 SHALL have port: cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port: rf_read_reg  out  5  register-file read index (async read port).
REQ-008 SHALL have port: rf_read_data  in  32  register-file read data, same cycle as rf_read_reg.
REQ-009 SHALL have ports: rf_we (out 1), rf_write_reg (out 5), rf_write_data (out 32), register-file write port.
REQ-010 SHALL have ports: dout_valid (out 1), dout_ready (in 1), dout_data (out 32), dout_last (out 1), dump stream.
REQ-011 SHALL have ports: din_valid (in 1), din_ready (out 1), din_data (in 32), load stream.
REQ-012 SHALL have port: core_halt  out  1  high whenever block is not IDLE; stalls core writes.

Function
REQ-013 SHALL implement FSM states IDLE, DUMP, LOAD and a 5-bit index idx.
REQ-014 cmd_ready SHALL be 1 only in IDLE and not in RST.
REQ-015 On cmd_valid && cmd_ready: next state DUMP (cmd_op=0) or LOAD (cmd_op=1); idx <= (DUMP && DUMP_ZERO==0) ? 1 : (DUMP ? 0 : 1).
REQ-016 rf_read_reg SHALL equal idx in DUMP, 0 otherwise.
REQ-017 DUMP: when not all words issued and (!dout_valid || dout_ready), SHALL register dout_data <= rf_read_data, dout_valid <= 1, dout_last <= (idx==31), idx <= idx+1.
REQ-018 DUMP: after the idx==31 word is issued, no further capture; idx wrap to 0 SHALL NOT cause a 33rd word.
REQ-019 dout_data/dout_last SHALL be stable while dout_valid && !dout_ready.
REQ-020 dout_valid SHALL drop when the held word is accepted and no new word is captured that cycle.
REQ-021 Accept of word with dout_last (dout_valid && dout_ready) SHALL return FSM to IDLE next cycle with dout_valid=0, dout_last=0.
REQ-022 Latency: command accepted in cycle T -> first dout_valid in T+2; with dout_ready held 1, one word per cycle, no bubbles.
REQ-023 LOAD: din_ready SHALL be 1 in LOAD only; on din_valid && din_ready, rf_we=1 combinationally, rf_write_reg=idx, rf_write_data=din_data, idx <= idx+1.
REQ-024 LOAD SHALL write x1..x31 (31 words, never x0); write to idx==31 SHALL return FSM to IDLE next cycle.
REQ-025 rf_we SHALL be 0 outside LOAD, when din_valid=0, and in any cycle RST=1.
REQ-026 cmd_valid while busy SHALL be ignored (not queued); cmd_op sampled only at accept.
REQ-027 din_valid in DUMP/IDLE SHALL be ignored; dout_ready in LOAD/IDLE SHALL be ignored.
REQ-028 core_halt SHALL be registered from state: 1 from T+1 through the last DUMP/LOAD cycle, 0 in IDLE.

Reset
REQ-029 RST=1 at any clock edge SHALL force IDLE, idx=0, dout_valid=0, dout_last=0, dout_data=0.
REQ-030 Reset mid-DUMP or mid-LOAD SHALL abort the operation; no partial resume, no rf_we in reset cycle.
REQ-031 In reset cycle combinational outputs SHALL be: cmd_ready=0, din_ready=0, rf_we=0, rf_read_reg=0, core_halt=0 after first reset edge.

Verification
REQ-032 RF preloaded x[i]=0x100+i, DUMP_ZERO=1, DUMP, dout_ready=1 -> 32 words 0x100..0x11F, consecutive, dout_last only on 0x11F, IDLE after.
REQ-033 DUMP_ZERO=0, DUMP, dout_ready toggling 1/0 each cycle -> 31 words 0x101..0x11F, no drops/duplicates, data stable while stalled.
REQ-034 LOAD, din_data=0xA000+k for k=1..31 with din_valid gaps -> rf writes x1..x31 = 0xA001..0xA01F, x0 never written, then IDLE.
REQ-035 cmd_valid held during DUMP with cmd_op=1 -> ignored; cmd_ready=0 until IDLE; next command accepted only after dout_last handshake.
REQ-036 RST=1 after 10th DUMP word / 5th LOAD write -> next cycle IDLE, dout_valid=0, core_halt=0, no rf_we; fresh DUMP starts again from x0.
